// File: rtl/arm_shift_pipe_if.sv
// Request/result bundle for the operand-2 shifter pipeline.
// The master drives requests and out_ready; the slave (the shifter) answers.
interface arm_shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int SA_W  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic             imm_mode;
    logic             reg_amt;
    logic [1:0]       shift_type;
    logic [SA_W-1:0]  sh_imm;
    logic [7:0]       rs_data;
    logic [3:0]       rot_imm;
    logic [7:0]       imm8;
    logic [WIDTH-1:0] rm_data;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport master (
        output in_valid, imm_mode, reg_amt, shift_type, sh_imm, rs_data,
               rot_imm, imm8, rm_data, carry_in, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, imm_mode, reg_amt, shift_type, sh_imm, rs_data,
               rot_imm, imm8, rm_data, carry_in, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/arm_shift_pipe.sv
// Two-stage ARM operand-2 barrel shifter with valid/ready flow control.
// Stage 1 decodes the shift request (amount, operation, pass-through);
// stage 2 performs the shift combinationally and registers data and carry.
// WIDTH must be a power of two and at least 16.
module arm_shift_pipe #(
    parameter int WIDTH = 32,
    parameter int SA_W  = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            reset,
    arm_shift_pipe_if.slave bus
);
    // Amount register must hold both an 8-bit Rs byte and the value WIDTH.
    localparam int AMT_W = (SA_W + 1 > 8) ? SA_W + 1 : 8;
    localparam logic [AMT_W-1:0] AMT_WIDTH = AMT_W'(WIDTH);

    typedef enum logic [2:0] {
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX,
        OP_IMM
    } op_e;

    typedef struct packed {
        op_e              op;
        logic             pass;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] rm;
        logic             cin;
        logic [7:0]       imm8;
        logic [3:0]       rot;
    } s1_t;

    logic             s1_valid_q;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_carry_q;
    logic             out_carry_d;

    logic             s2_adv;
    logic             s1_adv;

    logic [AMT_W-1:0] asr_amt;
    logic [SA_W-1:0]  imm_rot;
    logic [WIDTH:0]   asr_res;

    // Rotate right by r (r < WIDTH); a zero rotate shifts the left term fully out.
    function automatic logic [WIDTH-1:0] ror_f(input logic [WIDTH-1:0] x,
                                               input logic [SA_W-1:0]  r);
        return (x >> r) | (x << (WIDTH - 32'(r)));
    endfunction

    assign s2_adv   = !out_valid_q || out_ready_w();
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_carry = out_carry_q;

    function automatic logic out_ready_w();
        return bus.out_ready;
    endfunction

    // Decode: resolve effective amount, operation and the special zero encodings.
    always_comb begin
        // NOTE: every field gets a default first so no path can infer a latch.
        s1_d      = '0;
        s1_d.op   = OP_LSL;
        s1_d.rm   = bus.rm_data;
        s1_d.cin  = bus.carry_in;
        s1_d.imm8 = bus.imm8;
        s1_d.rot  = bus.rot_imm;
        s1_d.amt  = bus.reg_amt ? AMT_W'(bus.rs_data) : AMT_W'(bus.sh_imm);
        if (bus.imm_mode) begin
            s1_d.op = OP_IMM;
        end else begin
            unique case (bus.shift_type)
                2'b00: s1_d.op = OP_LSL;
                2'b01: s1_d.op = OP_LSR;
                2'b10: s1_d.op = OP_ASR;
                2'b11: s1_d.op = OP_ROR;
            endcase
            if (bus.reg_amt) begin
                // A zero register amount leaves the operand and C untouched.
                s1_d.pass = (bus.rs_data == 8'd0);
            end else if (bus.sh_imm == '0) begin
                // Immediate zero re-encodes: LSL #0 passes, LSR/ASR #0 mean #WIDTH, ROR #0 is RRX.
                unique case (bus.shift_type)
                    2'b00: s1_d.pass = 1'b1;
                    2'b01: s1_d.amt  = AMT_WIDTH;
                    2'b10: s1_d.amt  = AMT_WIDTH;
                    2'b11: s1_d.op   = OP_RRX;
                endcase
            end
        end
    end

    // Execute: single-cycle shift and carry-out from the decoded stage-1 fields.
    always_comb begin
        out_data_d  = s1_q.rm;
        out_carry_d = s1_q.cin;
        asr_amt     = (s1_q.amt > AMT_WIDTH) ? AMT_WIDTH : s1_q.amt;
        imm_rot     = SA_W'({s1_q.rot, 1'b0});
        asr_res     = $signed({s1_q.rm, 1'b0}) >>> asr_amt;
        if (!s1_q.pass) begin
            case (s1_q.op)
                // The extra bit beside the operand catches the last bit shifted out.
                OP_LSL: {out_carry_d, out_data_d} = {1'b0, s1_q.rm} << s1_q.amt;
                OP_LSR: {out_data_d, out_carry_d} = {s1_q.rm, 1'b0} >> s1_q.amt;
                OP_ASR: {out_data_d, out_carry_d} = asr_res;
                OP_ROR: begin
                    out_data_d  = ror_f(s1_q.rm, s1_q.amt[SA_W-1:0]);
                    out_carry_d = out_data_d[WIDTH-1];
                end
                OP_RRX: begin
                    out_data_d  = {s1_q.cin, s1_q.rm[WIDTH-1:1]};
                    out_carry_d = s1_q.rm[0];
                end
                OP_IMM: begin
                    out_data_d  = ror_f(WIDTH'(s1_q.imm8), imm_rot);
                    out_carry_d = (s1_q.rot == 4'd0) ? s1_q.cin : out_data_d[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    // Pipeline control and result register; these are the only reset state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q  <= out_data_d;
                    out_carry_q <= out_carry_d;
                end
            end
        end
    end

    // Stage-1 payload capture on each accepted request.
    always_ff @(posedge clk) begin
        // NOTE: payload needs no reset; s1_valid_q qualifies it and is itself reset.
        if (s1_adv && bus.in_valid) begin
            s1_q <= s1_d;
        end
    end
endmodule

// File: tb/tb_arm_shift_pipe.sv
// Directed self-checking bench for arm_shift_pipe: a WIDTH=32 and a WIDTH=16
// instance share clock and reset; each task drives one feature and checks inline.
module tb_arm_shift_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    arm_shift_pipe_if #(.WIDTH(32)) bus ();
    arm_shift_pipe_if #(.WIDTH(16)) bus16 ();

    arm_shift_pipe #(.WIDTH(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
    arm_shift_pipe #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    typedef struct {
        string       name;
        logic        imm_mode;
        logic        reg_amt;
        logic [1:0]  st;
        logic [4:0]  sh;
        logic [7:0]  rs;
        logic [3:0]  rot;
        logic [7:0]  imm8;
        logic [31:0] rm;
        logic        cin;
        logic [31:0] exp_d;
        logic        exp_c;
    } vec_t;

    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

    function automatic vec_t mk(string name, logic im, logic ra, logic [1:0] st,
                                logic [4:0] sh, logic [7:0] rs, logic [3:0] rot,
                                logic [7:0] i8, logic [31:0] rm, logic cin,
                                logic [31:0] ed, logic ec);
        vec_t v;
        v.name = name; v.imm_mode = im; v.reg_amt = ra; v.st = st; v.sh = sh;
        v.rs = rs; v.rot = rot; v.imm8 = i8; v.rm = rm; v.cin = cin;
        v.exp_d = ed; v.exp_c = ec;
        return v;
    endfunction

    task automatic drive32(input vec_t v);
        bus.imm_mode = v.imm_mode; bus.reg_amt = v.reg_amt; bus.shift_type = v.st;
        bus.sh_imm = v.sh; bus.rs_data = v.rs; bus.rot_imm = v.rot; bus.imm8 = v.imm8;
        bus.rm_data = v.rm; bus.carry_in = v.cin; bus.in_valid = 1'b1;
    endtask

    // One request on the 32-bit instance: accepted at edge k, sampled after edge k+1.
    task automatic issue32(input vec_t v, output logic rdy, output logic early,
                           output logic gv, output logic [31:0] gd, output logic gc);
        @(negedge clk);
        drive32(v);
        #1 rdy = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        early = bus.out_valid;
        @(posedge clk);
        @(negedge clk);
        gv = bus.out_valid; gd = bus.out_data; gc = bus.out_carry;
    endtask

    task automatic issue16(input vec_t v, output logic rdy, output logic gv,
                           output logic [15:0] gd, output logic gc);
        @(negedge clk);
        bus16.imm_mode = v.imm_mode; bus16.reg_amt = v.reg_amt; bus16.shift_type = v.st;
        bus16.sh_imm = v.sh[3:0]; bus16.rs_data = v.rs; bus16.rot_imm = v.rot;
        bus16.imm8 = v.imm8; bus16.rm_data = v.rm[15:0]; bus16.carry_in = v.cin;
        bus16.in_valid = 1'b1;
        #1 rdy = bus16.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        gv = bus16.out_valid; gd = bus16.out_data; gc = bus16.out_carry;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.imm_mode = 0; bus.reg_amt = 0; bus.shift_type = 0;
        bus.sh_imm = 0; bus.rs_data = 0; bus.rot_imm = 0; bus.imm8 = 0;
        bus.rm_data = 0; bus.carry_in = 0; bus.out_ready = 1;
        bus16.in_valid = 0; bus16.imm_mode = 0; bus16.reg_amt = 0; bus16.shift_type = 0;
        bus16.sh_imm = 0; bus16.rs_data = 0; bus16.rot_imm = 0; bus16.imm8 = 0;
        bus16.rm_data = 0; bus16.carry_in = 0; bus16.out_ready = 1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
        n_vec++; if (bus.out_carry !== 1'b0) begin n_err++; $display("FAIL reset out_carry: got %b want 0", bus.out_carry); end
        n_vec++; if (bus16.out_valid !== 1'b0) begin n_err++; $display("FAIL reset16 out_valid: got %b want 0", bus16.out_valid); end
        n_vec++; if (bus16.in_ready !== 1'b1) begin n_err++; $display("FAIL reset16 in_ready: got %b want 1", bus16.in_ready); end
        n_vec++; if (bus16.out_data !== 16'h0) begin n_err++; $display("FAIL reset16 out_data: got %h want 0", bus16.out_data); end
    endtask

    task automatic test_lsl_lsr();
        vec_t t [$];
        logic rdy, early, gv, gc;
        logic [31:0] gd;
        t.push_back(mk("reg_lsl_1",  0, 1, LSL, 0,  1,  0, 0, 32'h8000_0001, 0, 32'h0000_0002, 1));
        t.push_back(mk("imm_lsr_0",  0, 0, LSR, 0,  0,  0, 0, 32'h8000_0001, 0, 32'h0000_0000, 1));
        t.push_back(mk("reg_lsr_33", 0, 1, LSR, 0,  33, 0, 0, 32'h8000_0001, 0, 32'h0000_0000, 0));
        t.push_back(mk("reg_lsr_1",  0, 1, LSR, 0,  1,  0, 0, 32'h8000_0001, 0, 32'h4000_0000, 1));
        t.push_back(mk("imm_lsl_0",  0, 0, LSL, 0,  0,  0, 0, 32'h8000_0001, 0, 32'h8000_0001, 0));
        t.push_back(mk("reg_lsl_32", 0, 1, LSL, 0,  32, 0, 0, 32'h8000_0001, 0, 32'h0000_0000, 1));
        t.push_back(mk("imm_lsl_4",  0, 0, LSL, 4,  0,  0, 0, 32'h8000_0001, 0, 32'h0000_0010, 0));
        t.push_back(mk("reg_lsr_32", 0, 1, LSR, 0,  32, 0, 0, 32'h8000_0001, 0, 32'h0000_0000, 1));
        t.push_back(mk("imm_lsr_31", 0, 0, LSR, 31, 0,  0, 0, 32'h8000_0001, 0, 32'h0000_0001, 0));
        foreach (t[i]) begin
            issue32(t[i], rdy, early, gv, gd, gc);
            n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL lsl_lsr/%s in_ready: got %b want 1", t[i].name, rdy); end
            n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL lsl_lsr/%s out_valid: got %b want 1", t[i].name, gv); end
            n_vec++; if (gd !== t[i].exp_d) begin n_err++; $display("FAIL lsl_lsr/%s data: got %h want %h", t[i].name, gd, t[i].exp_d); end
            n_vec++; if (gc !== t[i].exp_c) begin n_err++; $display("FAIL lsl_lsr/%s carry: got %b want %b", t[i].name, gc, t[i].exp_c); end
        end
    endtask

    task automatic test_asr_ror_rrx();
        vec_t t [$];
        logic rdy, early, gv, gc;
        logic [31:0] gd;
        t.push_back(mk("reg_asr_40", 0, 1, ASR, 0, 40, 0, 0, 32'h8000_00F0, 1, 32'hFFFF_FFFF, 1));
        t.push_back(mk("reg_ror_36", 0, 1, ROR, 0, 36, 0, 0, 32'h8000_00F0, 1, 32'h0800_000F, 0));
        t.push_back(mk("imm_rrx",    0, 0, ROR, 0, 0,  0, 0, 32'h8000_00F0, 1, 32'hC000_0078, 0));
        t.push_back(mk("imm_asr_4",  0, 0, ASR, 4, 0,  0, 0, 32'h8000_00F0, 1, 32'hF800_000F, 0));
        t.push_back(mk("imm_asr_0",  0, 0, ASR, 0, 0,  0, 0, 32'h8000_00F0, 1, 32'hFFFF_FFFF, 1));
        t.push_back(mk("reg_ror_32", 0, 1, ROR, 0, 32, 0, 0, 32'h8000_00F0, 1, 32'h8000_00F0, 1));
        t.push_back(mk("reg_asr_8",  0, 1, ASR, 0, 8,  0, 0, 32'h8000_00F0, 1, 32'hFF80_0000, 1));
        t.push_back(mk("imm_ror_8",  0, 0, ROR, 8, 0,  0, 0, 32'h8000_00F0, 1, 32'hF080_0000, 1));
        t.push_back(mk("imm_rrx_c0", 0, 0, ROR, 0, 0,  0, 0, 32'h0000_0001, 0, 32'h0000_0000, 1));
        foreach (t[i]) begin
            issue32(t[i], rdy, early, gv, gd, gc);
            n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL asr_ror/%s in_ready: got %b want 1", t[i].name, rdy); end
            n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL asr_ror/%s out_valid: got %b want 1", t[i].name, gv); end
            n_vec++; if (gd !== t[i].exp_d) begin n_err++; $display("FAIL asr_ror/%s data: got %h want %h", t[i].name, gd, t[i].exp_d); end
            n_vec++; if (gc !== t[i].exp_c) begin n_err++; $display("FAIL asr_ror/%s carry: got %b want %b", t[i].name, gc, t[i].exp_c); end
        end
    endtask

    task automatic test_zero_and_imm();
        vec_t t [$];
        logic rdy, early, gv, gc;
        logic [31:0] gd;
        t.push_back(mk("reg_lsr_0",   0, 1, LSR, 0, 0, 0,  8'h00, 32'h8000_00F0, 1, 32'h8000_00F0, 1));
        t.push_back(mk("reg_ror_0",   0, 1, ROR, 0, 0, 0,  8'h00, 32'h1234_5678, 0, 32'h1234_5678, 0));
        t.push_back(mk("reg_asr_0",   0, 1, ASR, 0, 0, 0,  8'h00, 32'h8000_0000, 1, 32'h8000_0000, 1));
        t.push_back(mk("imm_ff_r4",   1, 0, LSL, 0, 0, 4,  8'hFF, 32'h0,         0, 32'hFF00_0000, 1));
        t.push_back(mk("imm_ff_r0c0", 1, 0, LSL, 0, 0, 0,  8'hFF, 32'h0,         0, 32'h0000_00FF, 0));
        t.push_back(mk("imm_ff_r0c1", 1, 0, LSL, 0, 0, 0,  8'hFF, 32'h0,         1, 32'h0000_00FF, 1));
        t.push_back(mk("imm_03_r1",   1, 1, ROR, 0, 0, 1,  8'h03, 32'hFFFF_FFFF, 0, 32'hC000_0000, 1));
        t.push_back(mk("imm_80_r15",  1, 0, LSL, 0, 0, 15, 8'h80, 32'h0,         1, 32'h0000_0200, 0));
        foreach (t[i]) begin
            issue32(t[i], rdy, early, gv, gd, gc);
            n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL zero_imm/%s in_ready: got %b want 1", t[i].name, rdy); end
            n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL zero_imm/%s out_valid: got %b want 1", t[i].name, gv); end
            n_vec++; if (gd !== t[i].exp_d) begin n_err++; $display("FAIL zero_imm/%s data: got %h want %h", t[i].name, gd, t[i].exp_d); end
            n_vec++; if (gc !== t[i].exp_c) begin n_err++; $display("FAIL zero_imm/%s carry: got %b want %b", t[i].name, gc, t[i].exp_c); end
        end
    endtask

    // Six LSL ops on 0xC000_0003 by 1..6; out_ready low in cycles 1..3.
    task automatic test_back_pressure();
        logic [31:0] exp_d [6] = '{32'h8000_0006, 32'h0000_000C, 32'h0000_0018,
                                   32'h0000_0030, 32'h0000_0060, 32'h0000_00C0};
        logic        exp_c [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        exp_rdy [12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        int   wr = 0;
        int   rd = 0;
        logic acc, drn;
        for (int c = 0; c < 30 && rd < 6; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 1 && c <= 3);
            if (wr < 6) drive32(mk("bp", 0, 1, LSL, 0, 8'(wr + 1), 0, 0, 32'hC000_0003, 0, 0, 0));
            else bus.in_valid = 1'b0;
            #1;
            if (c < 12) begin
                n_vec++; if (bus.in_ready !== exp_rdy[c]) begin n_err++; $display("FAIL back_pressure in_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy[c]); end
            end
            if (c == 2 || c == 3) begin
                n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall out_valid c%0d: got %b want 1", c, bus.out_valid); end
                n_vec++; if (bus.out_data !== exp_d[0]) begin n_err++; $display("FAIL stall out_data c%0d: got %h want %h", c, bus.out_data, exp_d[0]); end
                n_vec++; if (bus.out_carry !== exp_c[0]) begin n_err++; $display("FAIL stall out_carry c%0d: got %b want %b", c, bus.out_carry, exp_c[0]); end
            end
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (drn) begin
                n_vec++; if (bus.out_data !== exp_d[rd]) begin n_err++; $display("FAIL order data #%0d: got %h want %h", rd, bus.out_data, exp_d[rd]); end
                n_vec++; if (bus.out_carry !== exp_c[rd]) begin n_err++; $display("FAIL order carry #%0d: got %b want %b", rd, bus.out_carry, exp_c[rd]); end
                rd++;
            end
            @(posedge clk);
            if (acc) wr++;
        end
        n_vec++; if (rd != 6) begin n_err++; $display("FAIL back_pressure drained: got %0d want 6 (timeout)", rd); end
        n_vec++; if (wr != 6) begin n_err++; $display("FAIL back_pressure accepted: got %0d want 6", wr); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL back_pressure extra result: got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        logic rdy, early, gv, gc;
        logic [31:0] gd;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive32(mk("a", 0, 1, LSL, 0, 1, 0, 0, 32'h8000_0001, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive32(mk("b", 0, 1, LSR, 0, 4, 0, 0, 32'h0000_00F0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full in_ready: got %b want 0", bus.in_ready); end
        n_vec++; if (bus.out_data !== 32'h0000_0002) begin n_err++; $display("FAIL full out_data: got %h want 00000002", bus.out_data); end
        n_vec++; if (bus.out_carry !== 1'b1) begin n_err++; $display("FAIL full out_carry: got %b want 1", bus.out_carry); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL mid_reset out_data: got %h want 0", bus.out_data); end
        n_vec++; if (bus.out_carry !== 1'b0) begin n_err++; $display("FAIL mid_reset out_carry: got %b want 0", bus.out_carry); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset in_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        issue32(mk("c", 1, 0, LSL, 0, 0, 4, 8'hFF, 32'h0, 0, 0, 0), rdy, early, gv, gd, gc);
        n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL post_reset stale result: got out_valid %b want 0", early); end
        n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL post_reset out_valid: got %b want 1", gv); end
        n_vec++; if (gd !== 32'hFF00_0000) begin n_err++; $display("FAIL post_reset data: got %h want ff000000", gd); end
        n_vec++; if (gc !== 1'b1) begin n_err++; $display("FAIL post_reset carry: got %b want 1", gc); end
    endtask

    task automatic test_width16();
        vec_t t [$];
        logic rdy, gv, gc;
        logic [15:0] gd;
        t.push_back(mk("reg_lsl_16", 0, 1, LSL, 0, 16, 0, 8'h00, 32'h0001, 0, 32'h0000, 1));
        t.push_back(mk("imm_81_r1",  1, 0, LSL, 0, 0,  1, 8'h81, 32'h0000, 1, 32'h4020, 0));
        t.push_back(mk("imm_lsr_0",  0, 0, LSR, 0, 0,  0, 8'h00, 32'h8000, 0, 32'h0000, 1));
        t.push_back(mk("reg_ror_20", 0, 1, ROR, 0, 20, 0, 8'h00, 32'h1234, 0, 32'h4123, 0));
        t.push_back(mk("imm_81_r8",  1, 0, LSL, 0, 0,  8, 8'h81, 32'h0000, 1, 32'h0081, 0));
        t.push_back(mk("reg_asr_17", 0, 1, ASR, 0, 17, 0, 8'h00, 32'h8000, 0, 32'hFFFF, 1));
        t.push_back(mk("imm_rrx",    0, 0, ROR, 0, 0,  0, 8'h00, 32'h0003, 1, 32'h8001, 1));
        foreach (t[i]) begin
            issue16(t[i], rdy, gv, gd, gc);
            n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL w16/%s in_ready: got %b want 1", t[i].name, rdy); end
            n_vec++; if (gv !== 1'b1) begin n_err++; $display("FAIL w16/%s out_valid: got %b want 1", t[i].name, gv); end
            n_vec++; if (gd !== t[i].exp_d[15:0]) begin n_err++; $display("FAIL w16/%s data: got %h want %h", t[i].name, gd, t[i].exp_d[15:0]); end
            n_vec++; if (gc !== t[i].exp_c) begin n_err++; $display("FAIL w16/%s carry: got %b want %b", t[i].name, gc, t[i].exp_c); end
        end
    endtask

    initial begin
        test_reset();
        test_lsl_lsr();
        test_asr_ror_rrx();
        test_zero_and_imm();
        test_back_pressure();
        test_reset_mid_stall();
        test_width16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
